// File: rtl/mem_lsu_pkg.sv
// Shared widths, memory-op encodings, FSM states and bus request bundle for the MEM-stage LSU.
package mem_lsu_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int RADDR_WIDTH = 5;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            be;
        logic [DATA_WIDTH-1:0] wdata;
    } dbus_req_t;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store be/wdata, misalignment detect, load lane extract with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; stateless.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [3:0]            op_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] sdata_i,
    input  logic [3:0]            ld_op_i,
    input  logic [1:0]            ld_off_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output dbus_req_t             bus_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] ldata_o
);
    logic [1:0]            off;
    logic [DATA_WIDTH-1:0] lane;

    always_comb begin
        off        = addr_i[1:0];
        bus_o      = '0;
        bus_o.we   = is_store(op_i);
        bus_o.addr = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        misalign_o = 1'b0;
        case (op_i)
            MEM_LB, MEM_LBU, MEM_SB: bus_o.be = 4'b0001 << off;
            MEM_LH, MEM_LHU, MEM_SH: begin
                bus_o.be   = off[1] ? 4'b1100 : 4'b0011;
                misalign_o = off[0];
            end
            MEM_LW, MEM_SW: begin
                bus_o.be   = 4'b1111;
                misalign_o = |off;
            end
            default: ;
        endcase
        case (op_i)
            MEM_SB:  bus_o.wdata = {4{sdata_i[7:0]}};
            MEM_SH:  bus_o.wdata = {2{sdata_i[15:0]}};
            MEM_SW:  bus_o.wdata = sdata_i;
            default: ;
        endcase
    end

    // Loads use the offset captured at issue, since the response arrives later.
    always_comb begin
        lane = rdata_i >> {ld_off_i, 3'b000};
        case (ld_op_i)
            MEM_LB:  ldata_o = {{24{lane[7]}}, lane[7:0]};
            MEM_LBU: ldata_o = {24'd0, lane[7:0]};
            MEM_LH:  ldata_o = {{16{lane[15]}}, lane[15:0]};
            MEM_LHU: ldata_o = {16'd0, lane[15:0]};
            MEM_LW:  ldata_o = lane;
            default: ldata_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: ALU pass-through plus load/store over a req/gnt/rvalid bus, stalling the pipe meanwhile.
// Latency: NOP/misaligned 0 cycles; memory op >= 3 cycles (issue, wait, done) with 2+ stall cycles.
// Backpressure: req held until gnt, stallreq_o high from issue until the DONE cycle.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    input  logic                   mem_we_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic [3:0]             mem_op_i,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
    output logic [3:0]             dbus_be_o,
    output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
    input  logic                   dbus_gnt_i,
    input  logic                   dbus_rvalid_i,
    input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o,
    output logic                   misalign_o,
    output logic                   stallreq_o
);
    lsu_state_e             state_q, state_d;
    logic [3:0]             op_q, op_d;
    logic [1:0]             off_q, off_d;
    logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                   we_q, we_d;
    dbus_req_t              bus_q, bus_d;
    logic [DATA_WIDTH-1:0]  ldata_q, ldata_d;

    dbus_req_t              issue_bus, out_bus;
    logic                   issue_misalign, req, stall, misalign, out_we;
    logic [DATA_WIDTH-1:0]  ext_ldata, out_wdata;
    logic [RADDR_WIDTH-1:0] out_waddr;

    // The op code alone decides load vs store; the separate store flag is redundant.
    logic unused_mem_we;
    assign unused_mem_we = mem_we_i;

    mem_lsu_align u_align (
        .op_i       (mem_op_i),
        .addr_i     (mem_addr_i),
        .sdata_i    (mem_data_i),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .rdata_i    (dbus_rdata_i),
        .bus_o      (issue_bus),
        .misalign_o (issue_misalign),
        .ldata_o    (ext_ldata)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        off_d     = off_q;
        waddr_d   = waddr_q;
        we_d      = we_q;
        bus_d     = bus_q;
        ldata_d   = ldata_q;
        req       = 1'b0;
        stall     = 1'b0;
        misalign  = 1'b0;
        out_bus   = '0;
        out_waddr = reg_waddr_i;
        out_we    = reg_we_i;
        out_wdata = reg_wdata_i;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_i inside {[MEM_LB:MEM_SW]}) begin
                    out_we = 1'b0;
                    if (issue_misalign) begin
                        misalign = 1'b1;
                    end else begin
                        req     = 1'b1;
                        stall   = 1'b1;
                        out_bus = issue_bus;
                        op_d    = mem_op_i;
                        off_d   = mem_addr_i[1:0];
                        waddr_d = reg_waddr_i;
                        we_d    = reg_we_i;
                        bus_d   = issue_bus;
                        state_d = dbus_gnt_i ? ST_WAIT : ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                req       = 1'b1;
                stall     = 1'b1;
                out_bus   = bus_q;
                out_waddr = waddr_q;
                out_we    = 1'b0;
                if (dbus_gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                stall     = 1'b1;
                out_waddr = waddr_q;
                out_we    = 1'b0;
                if (dbus_rvalid_i) begin
                    state_d = ST_DONE;
                    if (is_load(op_q)) ldata_d = ext_ldata;
                end
            end
            default: begin
                out_waddr = waddr_q;
                out_we    = is_load(op_q) & we_q;
                out_wdata = is_load(op_q) ? ldata_q : '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            op_q    <= MEM_NOP;
            off_q   <= '0;
            waddr_q <= ZERO_REG;
            we_q    <= 1'b0;
            bus_q   <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            bus_q   <= bus_d;
            ldata_q <= ldata_d;
        end
    end

    // While reset is held the FSM sits in IDLE, which would otherwise echo live inputs.
    always_comb begin
        dbus_req_o   = rst_n_i & req;
        dbus_we_o    = rst_n_i & out_bus.we;
        dbus_addr_o  = rst_n_i ? out_bus.addr : '0;
        dbus_be_o    = rst_n_i ? out_bus.be : '0;
        dbus_wdata_o = rst_n_i ? out_bus.wdata : '0;
        reg_waddr_o  = rst_n_i ? out_waddr : ZERO_REG;
        reg_we_o     = rst_n_i & out_we;
        reg_wdata_o  = rst_n_i ? out_wdata : '0;
        misalign_o   = rst_n_i & misalign;
        stallreq_o   = rst_n_i & stall;
    end

endmodule
